// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ALU initiator with 2**REG_AW-entry register file and status register.
// Optional B-operand shifter enabled by defining SHIFTER_EN.
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rn,
  input  logic [REG_AW-1:0] cmd_rm,
  input  logic [1:0]        cmd_shift,
  input  logic              cmd_setflags,
  input  logic              cmd_nowrite,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_ain,
  output logic [DATA_W-1:0] alu_bin,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_status,
  output logic [2:0]        status_q,
  output logic              busy,
  output logic              done,
  input  logic [REG_AW-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3;
  logic [1:0] state;
  logic [DATA_W-1:0] r [2**REG_AW];
  logic [REG_AW-1:0] rd_q, rn_q, rm_q;
  logic sf_q, nw_q;
  logic [DATA_W-1:0] c_q, rm_val, b_src;
  logic [2:0] s_q;
  assign busy      = state != IDLE;
  assign cmd_ready = state == IDLE && !ld_valid;
  assign done      = state == WB;
  assign dbg_data  = r[dbg_sel];
  assign rm_val    = r[rm_q];
`ifdef SHIFTER_EN
  logic [1:0] sh_q;
  always_comb b_src = sh_q == 2'b01 ? {rm_val[DATA_W-2:0], 1'b0} :
                      sh_q == 2'b10 ? {1'b0, rm_val[DATA_W-1:1]} :
                      sh_q == 2'b11 ? {rm_val[DATA_W-1], rm_val[DATA_W-1:1]} : rm_val;
  always_ff @(posedge clk)
    if (reset) sh_q <= '0;
    else if (cmd_valid && cmd_ready) sh_q <= cmd_shift;
`else
  logic unused_shift;
  assign unused_shift = ^cmd_shift;
  assign b_src = rm_val;
`endif
  // status_q only moves in WB so an aborted command never exposes its flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      for (int i = 0; i < 2**REG_AW; i++) r[i] <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      sf_q     <= 1'b0;
      nw_q     <= 1'b0;
      alu_op   <= '0;
      alu_ain  <= '0;
      alu_bin  <= '0;
      c_q      <= '0;
      s_q      <= '0;
      status_q <= '0;
    end else begin
      state <= state == IDLE ? (cmd_valid && !ld_valid ? READ : IDLE) :
               state == WB ? IDLE : state + 2'd1;
      if (state == IDLE && ld_valid) r[ld_reg] <= ld_data;
      if (cmd_valid && cmd_ready) begin
        alu_op <= cmd_op;
        rd_q   <= cmd_rd;
        rn_q   <= cmd_rn;
        rm_q   <= cmd_rm;
        sf_q   <= cmd_setflags;
        nw_q   <= cmd_nowrite;
      end
      if (state == READ) begin
        alu_ain <= r[rn_q];
        alu_bin <= b_src;
      end
      if (state == EXEC) begin
        c_q <= alu_out;
        if (sf_q) s_q <= alu_status;
      end
      if (state == WB) begin
        if (!nw_q) r[rd_q] <= c_q;
        status_q <= s_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed test of alu_sequencer with a bench-side ALU and transaction-level model.
module tb_alu_sequencer;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0, cmd_shift = 0;
  logic [2:0] cmd_rd = 0, cmd_rn = 0, cmd_rm = 0;
  logic cmd_setflags = 0, cmd_nowrite = 0;
  logic ld_valid = 0;
  logic [2:0] ld_reg = 0;
  logic [15:0] ld_data = 0;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic [1:0] alu_op;
  logic [2:0] alu_status, status_q;
  logic busy, done;
  logic [2:0] dbg_sel = 0;
  logic [15:0] dbg_data;
  int checks = 0, errors = 0;
  bit armed = 0;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_shift(cmd_shift), .cmd_setflags(cmd_setflags), .cmd_nowrite(cmd_nowrite),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_status(alu_status), .status_q(status_q),
    .busy(busy), .done(done), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // returns {N,V,Z,out}
  function automatic logic [18:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic [15:0] o;
    logic v;
    o = op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : ~b;
    v = op == 2'd0 ? (a[15] == b[15] && o[15] != a[15]) :
        op == 2'd1 ? (a[15] != b[15] && o[15] != a[15]) : 1'b0;
    return {o[15], v, o == 16'd0, o};
  endfunction

  function automatic logic [15:0] shf(input logic [15:0] x, input logic [1:0] sh);
`ifdef SHIFTER_EN
    case (sh)
      2'd1: return x << 1;
      2'd2: return x >> 1;
      2'd3: return $signed(x) >>> 1;
      default: return x;
    endcase
`else
    return sh == 2'd0 ? x : x;
`endif
  endfunction

  assign {alu_status, alu_out} = alu_fn(alu_ain, alu_bin, alu_op);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // transaction model: ph counts cycles since acceptance, result computed at acceptance
  logic [15:0] m_r [8];
  logic [15:0] m_a, m_b, m_res;
  logic [1:0] m_op;
  logic [2:0] m_s, m_st, m_rd;
  logic m_nw;
  int ph = 0;
  logic [18:0] m_tmp;
  initial for (int i = 0; i < 8; i++) m_r[i] = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_r[i] = 0;
      m_s = 0; m_st = 0; ph = 0;
    end else if (ph == 0) begin
      if (ld_valid) m_r[ld_reg] = ld_data;
      else if (cmd_valid) begin
        m_a = m_r[cmd_rn];
        m_b = shf(m_r[cmd_rm], cmd_shift);
        m_op = cmd_op;
        m_tmp = alu_fn(m_a, m_b, cmd_op);
        m_res = m_tmp[15:0];
        if (cmd_setflags) m_s = m_tmp[18:16];
        m_rd = cmd_rd;
        m_nw = cmd_nowrite;
        ph = 1;
      end
    end else if (ph == 3) begin
      if (!m_nw) m_r[m_rd] = m_res;
      m_st = m_s;
      ph = 0;
    end else ph++;
  end

  always @(negedge clk) if (armed) begin
    chk("busy", busy, ph != 0);
    chk("done", done, ph == 3);
    chk("cmd_ready", cmd_ready, ph == 0 && !ld_valid);
    chk("status_q", status_q, m_st);
    chk("dbg_data", dbg_data, m_r[dbg_sel]);
    if (ph == 2) begin
      chk("alu_ain", alu_ain, m_a);
      chk("alu_bin", alu_bin, m_b);
      chk("alu_op", alu_op, m_op);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ld(input logic [2:0] rg, input logic [15:0] d);
    ld_valid = 1; ld_reg = rg; ld_data = d;
    step();
    ld_valid = 0;
  endtask

  task automatic peek(input string nm, input logic [2:0] sel, input logic [15:0] exp);
    dbg_sel = sel;
    @(negedge clk);
    chk(nm, dbg_data, exp);
    step();
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [1:0] sh, input logic sf, input logic nw);
    int n;
    cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_shift = sh;
    cmd_setflags = sf; cmd_nowrite = nw; cmd_valid = 1;
    step();
    cmd_valid = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 8);
    chk("done_latency", n, 3);
    step();
  endtask

  initial begin
    repeat (2) step();
    reset = 0;
    armed = 1;
    for (int i = 0; i < 8; i++) peek("reset_reg", i[2:0], 16'h0);
    @(negedge clk);
    chk("reset_status", status_q, 3'b000);
    chk("reset_ready", cmd_ready, 1);
    step();

    ld(1, 5); ld(2, 3);
    issue(2'd0, 3, 1, 2, 2'd0, 1, 0);
    peek("add_r3", 3, 16'd8);
    chk("add_status", status_q, 3'b000);
    chk("model_r3", m_r[3], 16'd8);

    ld(2, 5);
    issue(2'd1, 4, 1, 2, 2'd0, 1, 1);
    peek("cmp_r4", 4, 16'd0);
    chk("cmp_status", status_q, 3'b001);

    ld(1, 16'h7FFF); ld(2, 1);
    issue(2'd0, 3, 1, 2, 2'd0, 1, 0);
    peek("ovf_r3", 3, 16'h8000);
    chk("ovf_status", status_q, 3'b110);
    chk("model_ovf", m_r[3], 16'h8000);

    ld(2, 16'h8002);
    issue(2'd3, 5, 1, 2, 2'd3, 0, 0);
`ifdef SHIFTER_EN
    peek("notb_asr_r5", 5, 16'h3FFE);
`else
    peek("notb_r5", 5, 16'h7FFD);
`endif
    chk("notb_status_kept", status_q, 3'b110);

    ld(1, 16'hF0F0); ld(2, 16'h0FF0);
    issue(2'd2, 1, 1, 2, 2'd0, 1, 0);
    peek("and_rd_eq_rn", 1, 16'h00F0);
    chk("and_status", status_q, 3'b000);

    issue(2'd0, 1, 1, 1, 2'd1, 0, 1);
    peek("noop_r1", 1, 16'h00F0);

    issue(2'd0, 6, 2, 2, 2'd2, 1, 0);
    issue(2'd1, 7, 1, 2, 2'd0, 1, 0);
    peek("sub_neg_r7", 7, 16'hF100);
    chk("sub_neg_status", status_q, 3'b100);

    cmd_op = 0; cmd_rd = 3; cmd_rn = 1; cmd_rm = 2; cmd_setflags = 1; cmd_nowrite = 0;
    cmd_valid = 1;
    step();
    cmd_valid = 0;
    step();
    reset = 1;
    @(negedge clk);
    chk("abort_in_exec", busy, 1);
    step();
    reset = 0;
    peek("abort_r3", 3, 16'h0);
    chk("abort_status", status_q, 3'b000);

    ld_valid = 1; ld_reg = 6; ld_data = 16'h1234;
    cmd_valid = 1; cmd_op = 0; cmd_rd = 7; cmd_rn = 6; cmd_rm = 6;
    @(negedge clk);
    chk("collide_ready", cmd_ready, 0);
    step();
    ld_valid = 0; cmd_valid = 0;
    @(negedge clk);
    chk("collide_idle", busy, 0);
    step();
    peek("collide_r6", 6, 16'h1234);
    peek("collide_r7", 7, 16'h0);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
